// File: rtl/freq_seq_pkg.sv
// Shared types and constants for the frequency-divider step sequencer.
// The optional pause input is enabled with FREQ_SEQ_PAUSE_EN.
package freq_seq_pkg;
  localparam int SEL_W      = 3;
  localparam int DIV_M      = 9;
  localparam int STEP_DUR_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic [SEL_W-1:0]      sel;
    logic [STEP_DUR_W-1:0] dur;
  } step_t;

  // Divider period in clk cycles for a given select.
  function automatic int unsigned period(input logic [SEL_W-1:0] sel);
    return 32'd256 - (32'd32 * 32'(sel));
  endfunction
endpackage

// File: rtl/freq_step_table.sv
// Step table: one write port, two combinational read ports, cleared on reset.
module freq_step_table
  import freq_seq_pkg::*;
#(
  parameter int DEPTH_W = 3,
  parameter int DUR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [SEL_W-1:0]   wsel,
  input  logic [DUR_W-1:0]   wdur,
  input  logic [DEPTH_W-1:0] raddr0,
  output logic [SEL_W-1:0]   rsel0,
  output logic [DUR_W-1:0]   rdur0,
  input  logic [DEPTH_W-1:0] raddr1,
  output logic [SEL_W-1:0]   rsel1,
  output logic [DUR_W-1:0]   rdur1
);
  localparam int N = 2**DEPTH_W;

  logic [N-1:0][SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0][DUR_W-1:0] dur_q, dur_d;

  always_comb begin
    sel_d = sel_q;
    dur_d = dur_q;
    if (we) begin
      sel_d[waddr] = wsel;
      dur_d[waddr] = wdur;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= '0;
      dur_q <= '0;
    end else begin
      sel_q <= sel_d;
      dur_q <= dur_d;
    end
  end

  assign rsel0 = sel_q[raddr0];
  assign rdur0 = dur_q[raddr0];
  assign rsel1 = sel_q[raddr1];
  assign rdur1 = dur_q[raddr1];
endmodule

// File: rtl/freq_seq_ctrl.sv
// Plays a programmed list of (select, duration) steps on the 9-bit loadable divider.
// Define FREQ_SEQ_PAUSE_EN to add the pause input.
module freq_seq_ctrl
  import freq_seq_pkg::*;
#(
  parameter int DEPTH_W = 3,
  parameter int DUR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [DEPTH_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [DUR_W-1:0]   cfg_dur,
  input  logic               start,
  input  logic [DEPTH_W-1:0] len,
  input  logic               loop,
  input  logic               stop,
`ifdef FREQ_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               div_co,
  output logic               div_ld,
  output logic [SEL_W-1:0]   div_cnt,
  output logic               busy,
  output logic               done,
  output logic [DEPTH_W-1:0] step_idx,
  output logic               tone_out
);
  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] idx_q, idx_d, last_q, last_d, nxt_idx;
  logic [DUR_W-1:0]   rem_q, rem_d, cur_dur, nxt_dur, cur_rem, nxt_rem;
  logic [SEL_W-1:0]   cur_sel, nxt_sel;
  logic               loop_q, loop_d, busy_q, busy_d, done_q, done_d, tone_q, tone_d;
  logic               pause_w;

`ifdef FREQ_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Second read port looks one step ahead, wrapping to 0 after the last step.
  assign nxt_idx = (idx_q == last_q) ? '0 : idx_q + DEPTH_W'(1);
  assign cur_rem = (cur_dur == '0) ? DUR_W'(1) : cur_dur;
  assign nxt_rem = (nxt_dur == '0) ? DUR_W'(1) : nxt_dur;

  freq_step_table #(.DEPTH_W(DEPTH_W), .DUR_W(DUR_W)) u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && (state_q == IDLE)),
    .waddr (cfg_addr),
    .wsel  (cfg_sel),
    .wdur  (cfg_dur),
    .raddr0(idx_q),
    .rsel0 (cur_sel),
    .rdur0 (cur_dur),
    .raddr1(nxt_idx),
    .rsel1 (nxt_sel),
    .rdur1 (nxt_dur)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    rem_d   = rem_q;
    tone_d  = tone_q;
    div_ld  = 1'b0;
    div_cnt = cur_sel;
    case (state_q)
      IDLE: if (start) begin
        last_d  = len;
        loop_d  = loop;
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        div_ld  = 1'b1;
        rem_d   = cur_rem;
        state_d = RUN;
      end
      RUN: begin
        // Holding ld freezes the divider at its load value while paused.
        if (pause_w) begin
          div_ld = 1'b1;
        end else if (div_co) begin
          tone_d = ~tone_q;
          if (rem_q > DUR_W'(1)) begin
            div_ld = 1'b1;
            rem_d  = rem_q - DUR_W'(1);
          end else if (idx_q < last_q || loop_q) begin
            div_ld  = 1'b1;
            div_cnt = nxt_sel;
            idx_d   = nxt_idx;
            rem_d   = nxt_rem;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        tone_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      tone_d  = 1'b0;
      div_ld  = 1'b0;
    end
    busy_d = (state_d == LOAD) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tone_q  <= tone_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;
  assign tone_out = tone_q;
endmodule

// File: tb/tb_freq_seq_ctrl.sv
// Bench for freq_seq_ctrl: drives a model of the 9-bit divider and checks co timing,
// step order, tone and done against a per-pulse list built from the programmed table.
module tb_freq_seq_ctrl;
  import freq_seq_pkg::*;
  localparam int DW = 3;
  localparam int UW = 8;
  localparam int N  = 2**DW;

  logic          clk = 1'b0, rst = 1'b0;
  logic          cfg_we = 1'b0, start = 1'b0, loop = 1'b0, stop = 1'b0;
  logic [DW-1:0] cfg_addr = '0, len = '0;
  logic [2:0]    cfg_sel = '0;
  logic [UW-1:0] cfg_dur = '0;
  logic          div_co, div_ld, busy, done, tone_out;
  logic [2:0]    div_cnt;
  logic [DW-1:0] step_idx;
`ifdef FREQ_SEQ_PAUSE_EN
  logic          pause = 1'b0;
`endif

  freq_seq_ctrl #(.DEPTH_W(DW), .DUR_W(UW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_dur(cfg_dur), .start(start), .len(len), .loop(loop), .stop(stop),
`ifdef FREQ_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .div_co(div_co), .div_ld(div_ld), .div_cnt(div_cnt), .busy(busy), .done(done),
    .step_idx(step_idx), .tone_out(tone_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: the loadable divider the sequencer controls.
  logic [DIV_M-1:0] dcnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dcnt <= '0;
    else if (div_ld) dcnt <= {1'b1, div_cnt, 5'b0};
    else             dcnt <= dcnt + 1'b1;
  end
  assign div_co = (dcnt == '1);

  step_t tbl [N];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int s, input int d);
    cfg_we = 1'b1; cfg_addr = DW'(a); cfg_sel = 3'(s); cfg_dur = UW'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[a].sel = 3'(s);
    tbl[a].dur = UW'(d);
  endtask

  // nstop > 0 with lp=1: stop on the nstop-th co. disturb: write+start attempt mid-run.
  task automatic play(input int nlast, input bit lp, input int nstop, input bit disturb, input bit pz);
    int unsigned ep[$];
    int unsigned ei[$];
    int unsigned last_t;
    int          total, n, since, reps;
    bit          tone_e, pz_done;
    ep = {}; ei = {};
    reps = lp ? nstop : 1;
    for (int r = 0; r < reps; r++)
      for (int i = 0; i <= nlast; i++)
        for (int k = 0; k < ((tbl[i].dur == 0) ? 1 : int'(tbl[i].dur)); k++) begin
          ep.push_back(period(tbl[i].sel));
          ei.push_back(i);
        end
    total = lp ? nstop : ep.size();
    len = DW'(nlast); loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ld", div_ld, 1);
    chk("load_cnt", div_cnt, tbl[0].sel);
    chk("load_idx", step_idx, 0);
    last_t = cyc; n = 0; tone_e = 1'b0; since = 0; pz_done = 1'b0;
    while (n < total) begin
      @(negedge clk);
      since++;
      if (cyc - last_t > 300) begin
        chk("co_timeout", cyc - last_t, 0);
        break;
      end
      if (div_co) begin
        chk("co_period", cyc - last_t, ep[n]);
        chk("co_idx", step_idx, ei[n]);
        chk("tone_pre", tone_out, tone_e);
        tone_e = ~tone_e; last_t = cyc; n++; since = 0;
        if (n == total) begin
          if (lp) begin
            stop = 1'b1;
            #1 chk("stop_ld_co", div_ld, 0);
          end else chk("last_ld", div_ld, 0);
        end else begin
          chk("reload_ld", div_ld, 1);
          chk("reload_cnt", div_cnt, tbl[ei[n]].sel);
        end
      end else begin
        chk("run_ld0", div_ld, 0);
        chk("run_busy", busy, 1);
        chk("run_done0", done, 0);
        if (disturb && n == 1 && since == 5) begin
          cfg_we = 1'b1; cfg_addr = 3'd1; cfg_sel = 3'd5; cfg_dur = 8'd9;
          start = 1'b1; len = '0;
          @(negedge clk);
          cfg_we = 1'b0; start = 1'b0; since++;
        end
`ifdef FREQ_SEQ_PAUSE_EN
        if (pz && n == 1 && since == 10 && !pz_done) begin
          pause = 1'b1;
          repeat (50) begin
            @(negedge clk);
            chk("pause_ld", div_ld, 1);
            chk("pause_cnt", div_cnt, tbl[ei[n]].sel);
            chk("pause_tone", tone_out, tone_e);
          end
          pause = 1'b0;
          last_t = cyc - 1;
          pz_done = 1'b1;
        end
`endif
      end
    end
    if (lp) begin
      @(negedge clk);
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_tone", tone_out, 0);
      chk("stop_ld", div_ld, 0);
      repeat (3) begin
        @(negedge clk);
        chk("stop_nodone", done, 0);
        chk("stop_idle_busy", busy, 0);
      end
    end else begin
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_ld", div_ld, 0);
      chk("done_tone", tone_out, tone_e);
      @(negedge clk);
      chk("done_clr", done, 0);
      chk("done_tone_clr", tone_out, 0);
      chk("idle_ld", div_ld, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) tbl[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tone", tone_out, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_ld", div_ld, 0);
    rst = 1'b1;
    @(negedge clk);

    wr(0, 7, 3);
    play(0, 0, 0, 0, 0);

    wr(0, 7, 2); wr(1, 0, 1); wr(2, 4, 2);
    play(2, 0, 0, 0, 0);
    play(2, 1, 12, 0, 0);

    wr(0, 3, 0);
    play(2, 0, 0, 1, 0);
    play(2, 0, 0, 0, 0);
`ifdef FREQ_SEQ_PAUSE_EN
    play(2, 0, 0, 0, 1);
`endif

    repeat (4) begin
      for (int a = 0; a < N; a++) wr(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      play(int'($urandom_range(0, 3)), 0, 0, 0, 0);
    end
    play(int'($urandom_range(0, 3)), 1, int'($urandom_range(3, 8)), 0, 0);

    // Reset in the middle of a running sequence.
    len = 3'd2; loop = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tone", tone_out, 0);
    chk("mid_rst_idx", step_idx, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < N; i++) tbl[i] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    play(7, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_seq_ctrl.md
Name: freq_seq_ctrl

Overview:
Sequencer for the 9-bit loadable frequency divider (load value {1'b1, sel[2:0], 5'b0}, carry-out when the count reaches all-ones). Holds a small programmable table of steps. Each step is a frequency select plus a duration in divider periods. On start, it plays steps 0..len in order by driving the divider's ld/cnt and counting its co pulses. Output tone_out is the resulting square wave for the lab's tone/waveform output stage.

Parameters:
DEPTH_W, 3, step-table address width (2**DEPTH_W entries, default 8)
DUR_W, 8, step duration width, counted in divider periods

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  write step table entry; ignored while busy=1
cfg_addr  in  DEPTH_W  table entry index
cfg_sel  in  3  frequency select for entry (drives divider cnt)
cfg_dur  in  DUR_W  entry duration in divider periods; 0 treated as 1
start  in  1  begin sequence; sampled only in IDLE
len  in  DEPTH_W  index of last step, latched on start
loop  in  1  restart at step 0 after last step, latched on start
stop  in  1  abort, highest priority
div_co  in  1  divider carry-out
div_ld  out  1  divider load strobe
div_cnt  out  3  divider load select
busy  out  1  sequence active
done  out  1  one-cycle pulse, sequence completed normally
step_idx  out  DEPTH_W  current step index
tone_out  out  1  toggles on every counted div_co

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, tone_out, step_idx, duration counter = 0; every table entry sel=0, dur=0.
- div_ld and div_cnt are combinational from state, idx and div_co. Everything else is registered.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: busy=0, div_ld=0.
  - start=1 latches len and loop, sets idx=0, moves to LOAD.
  - Table writes are accepted only in IDLE.
- LOAD (1 cycle): div_ld=1, div_cnt=table[idx].sel; rem <= max(table[idx].dur,1); busy=1; moves to RUN.
- RUN, div_co=0: hold state, div_ld=0.
- RUN, div_co=1: tone_out toggles, div_ld=1 in the same cycle so the divider reloads with no lost cycle.
  - rem>1: rem--, div_cnt=table[idx].sel.
  - rem==1 and idx<last: idx++, div_cnt=table[idx+1].sel, rem <= max(table[idx+1].dur,1).
  - rem==1, idx==last, loop=1: idx=0, div_cnt=table[0].sel, rem reloaded from entry 0.
  - rem==1, idx==last, loop=0: div_ld=0, moves to DONE.
- DONE (1 cycle): done=1, busy=0, tone_out cleared; moves to IDLE.
- Divider period for select s is 256 - 32*s clk cycles (s=0 gives 256, s=7 gives 32).
- stop=1 in any state: next state IDLE, done not pulsed, tone_out=0, div_ld=0 that cycle. stop beats start and div_co.
- start while busy is ignored.
- len > 2**DEPTH_W-1 cannot occur (width-limited). len=0 is a single-step sequence.
- div_co outside RUN is ignored.

Optional Feature:
Macro FREQ_SEQ_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 in RUN:
  - div_ld held at 1 with the current step's sel, so the divider is frozen at its load value.
  - div_co is ignored; rem and tone_out hold.
  - Releasing pause resumes with a full fresh period.
- Not defined: no pause port; RUN behaves as above.

Decomposition:
- Package freq_seq_pkg holds:
  - state enum (IDLE/LOAD/RUN/DONE)
  - SEL_W=3, DIV_M=9
  - step struct {sel, dur}
  - period helper constant 256 - 32*sel, for bench use
- Sub-module freq_step_table: 2**DEPTH_W x (3+DUR_W) register file with async-reset clear, one write port, two combinational read ports (idx and idx+1/0).

Test Plan:
- Reset mid-RUN (rst low 1 cycle) -> busy=0, tone_out=0, table reads all zero.
- Program entry0={sel=7,dur=3}, len=0, loop=0, start -> div_ld in LOAD cycle; 3 div_co pulses 32 cycles apart; tone_out toggles 3 times; done one cycle after third co; busy low.
- Entries {7,2},{0,1},{4,2}, len=2 -> periods 32,32,256,128,128; step_idx 0,0,1,2,2; single done pulse.
- Same table with loop=1 for 12 co pulses, then stop -> step_idx wraps 2 to 0; IDLE next cycle; no done; div_ld=0.
- Entry {3,0} -> counted as dur 1 (one 160-cycle period). cfg_we while busy leaves table unchanged (read back after done). start during RUN ignored.
- With FREQ_SEQ_PAUSE_EN, pause for 50 cycles mid-step -> div_ld high throughout, rem unchanged; next co exactly 1 period after release.
